// File: rtl/control_fsm_if.sv
// Bundle of the instruction-fetch input and all decoded control strobes
// leaving the sequencing controller. The controller uses the master modport;
// the datapath (or a testbench standing in for it) uses the slave modport.
interface control_fsm_if;
    logic [15:0] Instr;
    logic        PC_Up;
    logic        PC_Clr;
    logic [15:0] IR_Q;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  State;
    logic        Halted;
    logic        Illegal;

    modport master (
        input  Instr,
        output PC_Up, PC_Clr, IR_Q, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State, Halted, Illegal
    );

    modport slave (
        output Instr,
        input  PC_Up, PC_Clr, IR_Q, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State, Halted, Illegal
    );
endinterface

// File: rtl/control_fsm.sv
// Instruction-sequencing controller for the 16-bit processor.
// FETCH latches the ROM word into IR, DECODE dispatches on IR[15:12], and
// each execute state emits Moore-style strobes for data memory, register
// file and ALU. Every output is a register loaded from the next state and
// next IR, so Instr never reaches an output combinationally.
// Optional feature macro: CU_ILLEGAL_TRAP_EN (undefined opcodes trap to
// HALT and raise Illegal; otherwise they execute as NOOP).
module control_fsm #(
    parameter int          LOAD_WAIT = 1,        // legal range 1..3
    parameter logic [15:0] IR_RESET  = 16'h0000
) (
    input  logic           Clock,
    input  logic           Clear,
    control_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_STORE  = 4'd4,
        S_LOAD_A = 4'd5,
        S_LOAD_B = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    typedef struct packed {
        logic       pc_up;
        logic       pc_clr;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra_addr;
        logic [3:0] rb_addr;
        logic [2:0] alu_s0;
        logic       halted;
    } ctrl_t;

    localparam logic [1:0] WAIT_LAST = 2'(LOAD_WAIT - 1);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [1:0]  cnt_q, cnt_d;
    ctrl_t       ctrl_q, ctrl_d;
`ifdef CU_ILLEGAL_TRAP_EN
    logic        illegal_q, illegal_d;
`endif

    // Moore decode: strobes as a pure function of state and IR.
    function automatic ctrl_t decode(input state_e st, input logic [15:0] ir);
        ctrl_t c;
        c = '0;
        case (st)
            S_INIT:   c.pc_clr = 1'b1;
            S_FETCH:  c.pc_up  = 1'b1;
            S_STORE: begin
                c.d_addr  = ir[11:4];
                c.ra_addr = ir[3:0];
                c.d_wr    = 1'b1;
            end
            S_LOAD_A: begin
                c.d_addr = ir[11:4];
                c.rf_s   = 1'b1;
            end
            S_LOAD_B: begin
                c.d_addr = ir[11:4];
                c.rf_s   = 1'b1;
                c.w_addr = ir[3:0];
                c.w_en   = 1'b1;
            end
            S_ADD, S_SUB: begin
                c.ra_addr = ir[11:8];
                c.rb_addr = ir[7:4];
                c.w_addr  = ir[3:0];
                c.w_en    = 1'b1;
                c.alu_s0  = (st == S_ADD) ? 3'b001 : 3'b010;
            end
            S_HALT:   c.halted = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Next-state, IR, wait-counter and next-output computation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_INIT:  state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus.Instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_q[15:12])
                    4'h0: state_d = S_NOOP;
                    4'h1: state_d = S_STORE;
                    4'h2: begin
                        state_d = S_LOAD_A;
                        cnt_d   = 2'd0;
                    end
                    4'h3: state_d = S_ADD;
                    4'h4: state_d = S_SUB;
                    4'h5: state_d = S_HALT;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
`else
                        state_d   = S_NOOP;
`endif
                    end
                endcase
            end
            S_NOOP, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
            S_LOAD_A: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_LOAD_B;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_LOAD_B: begin
                state_d = S_FETCH;
                cnt_d   = 2'd0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
        ctrl_d = decode(state_d, ir_d);
    end

    // Single state register; Clear overrides every transition, outputs registered.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (Clear) begin
            state_q <= S_INIT;
            ir_q    <= IR_RESET;
            cnt_q   <= 2'd0;
            ctrl_q  <= decode(S_INIT, IR_RESET);
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign bus.PC_Up      = ctrl_q.pc_up;
    assign bus.PC_Clr     = ctrl_q.pc_clr;
    assign bus.IR_Q       = ir_q;
    assign bus.D_Addr     = ctrl_q.d_addr;
    assign bus.D_Wr       = ctrl_q.d_wr;
    assign bus.RF_s       = ctrl_q.rf_s;
    assign bus.RF_W_Addr  = ctrl_q.w_addr;
    assign bus.RF_W_en    = ctrl_q.w_en;
    assign bus.RF_Ra_Addr = ctrl_q.ra_addr;
    assign bus.RF_Rb_Addr = ctrl_q.rb_addr;
    assign bus.ALU_s0     = ctrl_q.alu_s0;
    assign bus.State      = state_q;
    assign bus.Halted     = ctrl_q.halted;
`ifdef CU_ILLEGAL_TRAP_EN
    assign bus.Illegal    = illegal_q;
`else
    assign bus.Illegal    = 1'b0;
`endif
endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm with LOAD_WAIT=2. The stimulus process
// drives Clear/Instr and, after each edge, pushes the expected output
// snapshot for that cycle; the monitor pops and compares on the falling edge.
module tb_control_fsm;
    localparam logic [3:0] INIT = 4'd0, FETCH = 4'd1, DECODE = 4'd2,
                           NOOP = 4'd3, STORE = 4'd4, LOAD_A = 4'd5,
                           LOAD_B = 4'd6, ADD = 4'd7, SUB = 4'd8, HALT = 4'd9;

    typedef struct packed {
        logic [3:0]  state;
        logic        pc_up;
        logic        pc_clr;
        logic [15:0] ir;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  w_addr;
        logic        w_en;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        halted;
        logic        illegal;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    logic Clock;
    logic Clear;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    control_fsm_if bus ();

    control_fsm #(.LOAD_WAIT(2), .IR_RESET(16'h0000)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Expected strobes for a state, written from the instruction table.
    function automatic obs_t model(input logic [3:0] st, input logic [15:0] ir, input logic ill);
        obs_t o;
        o = '0;
        o.state   = st;
        o.ir      = ir;
        o.illegal = ill;
        case (st)
            INIT:   o.pc_clr = 1'b1;
            FETCH:  o.pc_up  = 1'b1;
            STORE:  begin o.d_addr = ir[11:4]; o.ra = ir[3:0]; o.d_wr = 1'b1; end
            LOAD_A: begin o.d_addr = ir[11:4]; o.rf_s = 1'b1; end
            LOAD_B: begin o.d_addr = ir[11:4]; o.rf_s = 1'b1; o.w_addr = ir[3:0]; o.w_en = 1'b1; end
            ADD:    begin o.ra = ir[11:8]; o.rb = ir[7:4]; o.w_addr = ir[3:0]; o.w_en = 1'b1; o.alu = 3'b001; end
            SUB:    begin o.ra = ir[11:8]; o.rb = ir[7:4]; o.w_addr = ir[3:0]; o.w_en = 1'b1; o.alu = 3'b010; end
            HALT:   o.halted = 1'b1;
            default: o = o;
        endcase
        return o;
    endfunction

    // Apply inputs, take one edge, then queue the expected post-edge snapshot.
    task automatic cyc(input logic clr, input logic [15:0] instr, input string tag,
                       input logic [3:0] st, input logic [15:0] ir, input logic ill = 1'b0);
        exp_t e;
        Clear     = clr;
        bus.Instr = instr;
        @(posedge Clock);
        #1;
        e.v   = model(st, ir, ill);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the DUT outputs against the scoreboard mid-cycle.
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = {bus.State, bus.PC_Up, bus.PC_Clr, bus.IR_Q, bus.D_Addr, bus.D_Wr,
                 bus.RF_s, bus.RF_W_Addr, bus.RF_W_en, bus.RF_Ra_Addr, bus.RF_Rb_Addr,
                 bus.ALU_s0, bus.Halted, bus.Illegal};
            check(e.tag, a, e.v);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        Clear     = 1'b1;
        bus.Instr = 16'h0000;

        // Reset: held two edges, then release into FETCH.
        cyc(1, 16'h0000, "reset1", INIT, 16'h0000);
        cyc(1, 16'h0000, "reset2", INIT, 16'h0000);
        cyc(0, 16'h0000, "first_fetch", FETCH, 16'h0000);

        // ADD 3123: FETCH -> DECODE -> ADD -> FETCH.
        cyc(0, 16'h3123, "add_decode", DECODE, 16'h3123);
        cyc(0, 16'h0000, "add_exec", ADD, 16'h3123);
        cyc(0, 16'h0000, "add_next_fetch", FETCH, 16'h3123);

        // LOAD 2A55 with two wait cycles: 5-cycle instruction.
        cyc(0, 16'h2A55, "load_decode", DECODE, 16'h2A55);
        cyc(0, 16'h0000, "load_a1", LOAD_A, 16'h2A55);
        cyc(0, 16'h0000, "load_a2", LOAD_A, 16'h2A55);
        cyc(0, 16'h0000, "load_b", LOAD_B, 16'h2A55);
        cyc(0, 16'h0000, "load_next_fetch", FETCH, 16'h2A55);

        // SUB 4456.
        cyc(0, 16'h4456, "sub_decode", DECODE, 16'h4456);
        cyc(0, 16'h0000, "sub_exec", SUB, 16'h4456);
        cyc(0, 16'h0000, "sub_next_fetch", FETCH, 16'h4456);

        // STORE 1F07.
        cyc(0, 16'h1F07, "store_decode", DECODE, 16'h1F07);
        cyc(0, 16'h0000, "store_exec", STORE, 16'h1F07);
        cyc(0, 16'h0000, "store_next_fetch", FETCH, 16'h1F07);

        // Clear during LOAD_A: back to INIT with IR reset, no write pulse.
        cyc(0, 16'h2A55, "midload_decode", DECODE, 16'h2A55);
        cyc(0, 16'h0000, "midload_a1", LOAD_A, 16'h2A55);
        cyc(1, 16'h0000, "midload_clear", INIT, 16'h0000);
        cyc(0, 16'h0000, "midload_fetch", FETCH, 16'h0000);

        // HALT 5000: held for 20 cycles with PC_Up low.
        cyc(0, 16'h5000, "halt_decode", DECODE, 16'h5000);
        for (int i = 0; i < 20; i++) cyc(0, 16'h0000, "halt_hold", HALT, 16'h5000);
        cyc(1, 16'h0000, "halt_clear", INIT, 16'h0000);
        cyc(0, 16'h0000, "halt_exit_fetch", FETCH, 16'h0000);

        // Undefined opcode F000.
        cyc(0, 16'hF000, "illegal_decode", DECODE, 16'hF000);
`ifdef CU_ILLEGAL_TRAP_EN
        cyc(0, 16'h0000, "illegal_trap", HALT, 16'hF000, 1'b1);
        cyc(0, 16'h0000, "illegal_hold", HALT, 16'hF000, 1'b1);
        cyc(0, 16'h0000, "illegal_hold2", HALT, 16'hF000, 1'b1);
        cyc(1, 16'h0000, "illegal_clear", INIT, 16'h0000, 1'b0);
        cyc(0, 16'h0000, "illegal_after_fetch", FETCH, 16'h0000, 1'b0);
`else
        cyc(0, 16'h0000, "illegal_as_noop", NOOP, 16'hF000);
        cyc(0, 16'h0000, "illegal_next_fetch", FETCH, 16'hF000);
        cyc(0, 16'h0000, "noop_decode", DECODE, 16'h0000);
        cyc(0, 16'h0000, "noop_exec", NOOP, 16'h0000);
`endif

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clock);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Instruction-sequencing controller for the 16-bit processor; sits directly downstream of the program counter.
- Fetches the instruction ROM word addressed by the PC output and latches it into an internal IR.
- Drives the PC increment and clear strobes.
- Decodes the IR into Moore-style control strobes for data memory, register file and ALU.

Parameters:
- LOAD_WAIT, 1: number of LOAD_A cycles spent waiting for the synchronous data-memory read. Legal range 1..3.
- IR_RESET, 16'h0000: IR value after reset. Decodes as NOOP.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge
- Clear  in  1  synchronous, active-high reset
- Instr  in  16  ROM data at the current PC address; valid combinationally during FETCH
- PC_Up  out  1  PC increment strobe
- PC_Clr  out  1  PC clear strobe
- IR_Q  out  16  current instruction register contents
- D_Addr  out  8  data-memory address
- D_Wr  out  1  data-memory write enable
- RF_s  out  1  register-file write-data mux select: 1 = data memory, 0 = ALU
- RF_W_Addr  out  4  register-file write address
- RF_W_en  out  1  register-file write enable
- RF_Ra_Addr  out  4  register-file read port A address
- RF_Rb_Addr  out  4  register-file read port B address
- ALU_s0  out  3  ALU op select: 000 = idle, 001 = ADD, 010 = SUB
- State  out  4  current state encoding, for debug/display
- Halted  out  1  high while in HALT
- Illegal  out  1  illegal-opcode flag; see Optional Feature

Behaviour:
- Reset:
  - Clear=1 at a rising edge forces state INIT, IR=IR_RESET and the LOAD wait counter to 0.
  - Clear overrides every transition, including mid-LOAD and HALT.
- Outputs and INIT:
  - All outputs are decoded from state and IR only; no combinational path from Instr to any output.
  - In INIT all strobes are 0 except PC_Clr=1.
  - INIT -> FETCH unconditionally.
- Instruction encoding, IR[15:12] opcode:
  - 0000 NOOP
  - 0001 STORE: D[IR[11:4]] <= R[IR[3:0]]
  - 0010 LOAD: R[IR[3:0]] <= D[IR[11:4]]
  - 0011 ADD: R[IR[3:0]] <= R[IR[11:8]] + R[IR[7:4]]
  - 0100 SUB: R[IR[3:0]] <= R[IR[11:8]] - R[IR[7:4]]
  - 0101 HALT
  - 0110-1111 undefined
- FETCH:
  - PC_Up=1; IR <= Instr at the edge.
  - The PC increments on the same edge, so IR always holds the word at the pre-increment address.
  - FETCH -> DECODE.
- DECODE: no strobes. Next state by opcode: NOOP, STORE, LOAD_A, ADD, SUB or HALT. Undefined opcodes go to NOOP by default.
- NOOP: no strobes; -> FETCH.
- STORE: D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_Wr=1; -> FETCH.
- LOAD_A:
  - D_Addr=IR[11:4], RF_s=1.
  - Held for LOAD_WAIT cycles via the wait counter, then -> LOAD_B.
- LOAD_B: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0], RF_W_en=1; -> FETCH. Counter cleared.
- ADD:
  - RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0].
  - ALU_s0=001, RF_s=0, RF_W_en=1.
  - -> FETCH.
- SUB: same as ADD with ALU_s0=010; -> FETCH.
- HALT: Halted=1, all strobes 0, PC frozen. Stays in HALT until Clear.
- Address outputs in idle states are don't-care but drive 0 (deterministic for the bench).
- Cycle counts:
  - NOOP/STORE/ADD/SUB: 3 cycles per instruction.
  - LOAD: 3+LOAD_WAIT cycles.
  - HALT: 2 cycles to enter.
- PC_Up is high exactly once per instruction. PC wrap at 7'd127 -> 0 is the PC's concern; this block is unaffected.
- Never assert D_Wr and RF_W_en in the same cycle.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN
- Defined: an undefined opcode in DECODE goes to HALT, and Illegal=1 from entering HALT until Clear.
- Undefined: undefined opcodes execute as NOOP, and Illegal is tied to 0.

Test Plan:
- Reset release:
  - Clear=1 for 2 edges, then 0 -> INIT with PC_Clr=1 for one cycle, then FETCH with PC_Up=1.
  - IR_Q=16'h0000 until the first FETCH edge.
- ADD: Instr=16'h3123 -> IR_Q=16'h3123; in the ADD state RF_Ra_Addr=1, RF_Rb_Addr=2, RF_W_Addr=3, ALU_s0=001, RF_W_en=1, RF_s=0. Next FETCH occurs exactly 3 cycles after the previous one.
- LOAD with LOAD_WAIT=2: Instr=16'h2A55 -> D_Addr=8'hA5 for LOAD_A,LOAD_A,LOAD_B; RF_W_en=1 only in LOAD_B with RF_W_Addr=5 and RF_s=1; 5-cycle instruction.
- STORE then HALT:
  - 16'h1F07: D_Wr=1 for one cycle, D_Addr=8'hF0, RF_Ra_Addr=7.
  - 16'h5000: Halted=1, PC_Up stays 0 for 20 cycles.
- Mid-LOAD reset: assert Clear during LOAD_A -> next edge is INIT, RF_W_en never pulses, IR_Q=IR_RESET.
- Illegal opcode Instr=16'hF000:
  - With CU_ILLEGAL_TRAP_EN: HALT and Illegal=1.
  - Without: NOOP, next FETCH 3 cycles later, Illegal=0.
